uart_doc_loader: RTL and testbench
==================================

UART_DOC_LOADER -- requirements
Module: uart_doc_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 Parameter COLS, default 20, document columns per row.
REQ-003 Parameter ROWS, default 15, document rows.
REQ-004 clk  input  1  system clock (100 MHz); one clock domain, all logic on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 RsRx  input  1  asynchronous UART receive line, 8N1, idle high.
REQ-007 enable  input  1  when low, received bytes are discarded.
REQ-008 doc_ready  input  1  document write port granted this cycle.
REQ-009 write_addr  output  9  document address {row[3:0], col[4:0]}.
REQ-010 write_data  output  8  character to write.
REQ-011 we  output  1  write request; held until accepted.
REQ-012 busy  output  1  high outside IDLE or while a write is pending.
REQ-013 frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-014 overrun  output  1  one-cycle pulse when a byte is lost to a pending write.
REQ-015 full  output  1  cursor is past the last cell.

Function
REQ-016 RsRx passes through a 2-flop synchronizer before any use; rst drives the synchronizer flops high.
REQ-017 Receive FSM states: IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge.
REQ-018 START samples at CLKS_PER_BIT/2; if the line is high there, return to IDLE (glitch).
REQ-019 DATA samples 8 bits LSB-first, each CLKS_PER_BIT after the previous sample.
REQ-020 STOP samples after CLKS_PER_BIT; 0 gives frame_error, byte dropped; 1 releases the byte; both return to IDLE.
REQ-021 Released byte handling: enable=0 -> drop; 0x20..0x7E -> write at cursor; 0x0D -> col=0, row+1, no write; 0x08 -> cursor back one cell (no-op at 0,0), then write 0x20 there; all others dropped.
REQ-022 A write sets we=1 with write_addr/write_data stable; it completes in the first cycle with doc_ready=1; we falls the next cycle.
REQ-023 The cursor advances on write completion for printable bytes only: col+1; col=COLS-1 wraps to col 0, row+1.
REQ-024 A row increment from row ROWS-1 sets full=1 and parks the cursor; printable, 0x0D and 0x08 bytes are dropped while full.
REQ-025 A byte released while we=1 is dropped and pulses overrun; the pending write is unaffected.
REQ-026 Byte release and write completion in the same cycle: the completion is processed first, then the new byte is accepted.
REQ-027 Counters are sized to hold CLKS_PER_BIT-1; the bit index is 3 bits.

Reset
REQ-028 On rst: FSM=IDLE, cursor=(0,0), we=0, write_addr=0, write_data=0, busy=0, frame_error=0, overrun=0, full=0.
REQ-029 rst mid-frame or mid-write aborts the frame or write immediately; a partial byte is never written.

Structure
REQ-030 A shared package holds the FSM state enum, control codes (CR 0x0D, BS 0x08, SPACE 0x20), and COLS/ROWS defaults.
REQ-031 One sub-module, uart_rx_core, holds the synchronizer, baud counter and FSM; it outputs byte_valid, byte_data and frame_error.
REQ-032 Cursor, control-code decode and the write handshake live in the top of uart_doc_loader.

Verification
REQ-033 CLKS_PER_BIT=16, send "AB", doc_ready=1 -> writes 0x41@0x000 then 0x42@0x001; cursor=(0,2).
REQ-034 At col 19 row 0, send 'Z' -> write@{0,19}, cursor=(1,0); at row 14 col 19, 'Z' -> write@{14,19}, full=1; a further 'Q' gives no we.
REQ-035 Send 0x0D at (3,7) -> cursor=(4,0), no we; send 0x08 at (4,0) -> write 0x20@{3,19}, cursor=(3,19).
REQ-036 Send a frame with stop bit 0 -> frame_error pulses once, no we; a 2-cycle low glitch on RsRx -> no activity, FSM back in IDLE.
REQ-037 Hold doc_ready=0 across two bytes -> first write held; second byte pulses overrun; raising doc_ready completes only the first write.
REQ-038 Assert rst during DATA bit 4 -> all outputs at reset values next cycle; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_doc_loader_pkg.sv
`default_nettype none
//==============================================================================
// Module   : uart_doc_loader_pkg
// Desc     : Shared receiver states, control codes and document geometry.
// Revision : 1.0 - initial release
//==============================================================================
package uart_doc_loader_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t c_ST_IDLE  = 2'd0;
    localparam rx_state_t c_ST_START = 2'd1;
    localparam rx_state_t c_ST_DATA  = 2'd2;
    localparam rx_state_t c_ST_STOP  = 2'd3;

    localparam logic [7:0] c_CR    = 8'h0D;
    localparam logic [7:0] c_BS    = 8'h08;
    localparam logic [7:0] c_SPACE = 8'h20;

    localparam int c_COLS_DEFAULT = 20;
    localparam int c_ROWS_DEFAULT = 15;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx_core
// Desc     : 8N1 UART receiver with input synchronizer and mid-bit sampling.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx_core
    import uart_doc_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error,
    output logic       rx_active
);

    localparam int c_CW   = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    rx_state_t       r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic            r_ferr;
    logic            w_fall;

    assign w_fall = r_rx_prev & ~r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) r_state <= c_ST_START;
                end
                c_ST_START: begin
                    // A line already high at mid-start is treated as a glitch.
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_sync2 ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_ST_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= c_ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_ST_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2) r_valid <= 1'b1;
                        else         r_ferr  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign byte_valid  = r_valid;
    assign byte_data   = r_shift;
    assign frame_error = r_ferr;
    assign rx_active   = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_doc_loader.sv
`default_nettype none
//==============================================================================
// Module   : uart_doc_loader
// Desc     : Types UART characters into a COLS x ROWS document via a write port.
// Revision : 1.0 - initial release
//==============================================================================
module uart_doc_loader
    import uart_doc_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int COLS         = c_COLS_DEFAULT,
    parameter int ROWS         = c_ROWS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RsRx,
    input  logic       enable,
    input  logic       doc_ready,
    output logic [8:0] write_addr,
    output logic [7:0] write_data,
    output logic       we,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun,
    output logic       full
);

    localparam logic [4:0] c_COL_LAST = 5'(COLS - 1);
    localparam logic [3:0] c_ROW_LAST = 4'(ROWS - 1);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_rx_active;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (RsRx),
        .byte_valid  (w_byte_valid),
        .byte_data   (w_byte_data),
        .frame_error (frame_error),
        .rx_active   (w_rx_active)
    );

    logic [4:0] r_col;
    logic [3:0] r_row;
    logic       r_full;
    logic       r_we;
    logic       r_adv;
    logic       r_overrun;
    logic [8:0] r_waddr;
    logic [7:0] r_wdata;

    logic       w_done;
    logic [4:0] w_col;
    logic [3:0] w_row;
    logic       w_full;
    logic [4:0] w_bs_col;
    logic [3:0] w_bs_row;

    // Cursor after this cycle's write completion, which a new byte then sees.
    always_comb begin
        w_done   = r_we & doc_ready;
        w_col    = r_col;
        w_row    = r_row;
        w_full   = r_full;
        if (w_done && r_adv) begin
            if (r_col == c_COL_LAST) begin
                if (r_row == c_ROW_LAST) begin
                    w_full = 1'b1;
                end else begin
                    w_row = r_row + 4'd1;
                    w_col = 5'd0;
                end
            end else begin
                w_col = r_col + 5'd1;
            end
        end
        w_bs_col = w_col;
        w_bs_row = w_row;
        if (w_col != 5'd0) begin
            w_bs_col = w_col - 5'd1;
        end else if (w_row != 4'd0) begin
            w_bs_row = w_row - 4'd1;
            w_bs_col = c_COL_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= 5'd0;
            r_row     <= 4'd0;
            r_full    <= 1'b0;
            r_we      <= 1'b0;
            r_adv     <= 1'b0;
            r_overrun <= 1'b0;
            r_waddr   <= 9'd0;
            r_wdata   <= 8'h00;
        end else begin
            r_overrun <= 1'b0;
            r_col     <= w_col;
            r_row     <= w_row;
            r_full    <= w_full;
            if (w_done) r_we <= 1'b0;
            if (w_byte_valid && enable) begin
                if (r_we && !doc_ready) begin
                    r_overrun <= 1'b1;
                end else if (!w_full) begin
                    if (is_printable(w_byte_data)) begin
                        r_we    <= 1'b1;
                        r_adv   <= 1'b1;
                        r_waddr <= {w_row, w_col};
                        r_wdata <= w_byte_data;
                    end else if (w_byte_data == c_CR) begin
                        if (w_row == c_ROW_LAST) begin
                            r_full <= 1'b1;
                        end else begin
                            r_row <= w_row + 4'd1;
                            r_col <= 5'd0;
                        end
                    end else if (w_byte_data == c_BS) begin
                        r_row   <= w_bs_row;
                        r_col   <= w_bs_col;
                        r_we    <= 1'b1;
                        r_adv   <= 1'b0;
                        r_waddr <= {w_bs_row, w_bs_col};
                        r_wdata <= c_SPACE;
                    end
                end
            end
        end
    end

    assign write_addr = r_waddr;
    assign write_data = r_wdata;
    assign we         = r_we;
    assign overrun    = r_overrun;
    assign full       = r_full;
    assign busy       = w_rx_active | r_we;

endmodule
`default_nettype wire

// File: tb/tb_uart_doc_loader.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_doc_loader
// Desc     : Scoreboard bench with a character-level document model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_doc_loader;

    localparam int c_CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RsRx = 1'b1;
    logic       enable = 1'b1;
    logic       doc_ready = 1'b1;
    logic [8:0] write_addr;
    logic [7:0] write_data;
    logic       we;
    logic       busy;
    logic       frame_error;
    logic       overrun;
    logic       full;

    uart_doc_loader #(
        .CLKS_PER_BIT (c_CPB),
        .COLS         (20),
        .ROWS         (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RsRx        (RsRx),
        .enable      (enable),
        .doc_ready   (doc_ready),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .we          (we),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun),
        .full        (full)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          fe_seen = 0;
    int          ov_seen = 0;
    int          fe_exp = 0;
    int          ov_exp = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          m_row = 0;
    int          m_col = 0;
    bit          m_full = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Document model: 20 columns by 15 rows, address = row*32 + col.
    task automatic model_advance();
        if (m_col == 19) begin
            if (m_row == 14) m_full = 1'b1;
            else begin m_row++; m_col = 0; end
        end else begin
            m_col++;
        end
    endtask

    task automatic model_apply(input logic [7:0] b, input logic en);
        if (!en || m_full) return;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({9'(m_row * 32 + m_col), b});
            model_advance();
        end else if (b == 8'h0D) begin
            if (m_row == 14) m_full = 1'b1;
            else begin m_row++; m_col = 0; end
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
            else if (m_row > 0) begin m_row--; m_col = 19; end
            exp_q.push_back({9'(m_row * 32 + m_col), 8'h20});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RsRx = 1'b0;
        repeat (c_CPB) tick();
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            repeat (c_CPB) tick();
        end
        RsRx = stop_bit;
        repeat (c_CPB) tick();
        RsRx = 1'b1;
        repeat (6) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_apply(b, enable);
        send_frame(b, 1'b1);
    endtask

    task automatic apply_reset();
        check("queue_empty_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        m_full = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, int'(we), 0);
        check({tag, "_write_addr"}, int'(write_addr), 0);
        check({tag, "_write_data"}, int'(write_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_error"}, int'(frame_error), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_full"}, int'(full), 0);
    endtask

    // Monitor: a write is consumed at the edge following we && doc_ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_error) fe_seen++;
            if (overrun) ov_seen++;
            if (we && doc_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             write_addr, write_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", int'(write_addr), int'(mon_e[16:8]));
                    check("write_data", int'(write_data), int'(mon_e[7:0]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) doc_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         r;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic string, then walk to the end of row 0 and wrap.
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        while (m_col != 19) send_byte(8'($urandom_range(33, 126)));
        send_byte(8'h5A);
        send_byte(8'h61);

        // Fill to the last cell of the last row.
        while (m_row != 14) send_byte(8'h0D);
        while (m_col != 19) send_byte(8'($urandom_range(33, 126)));
        send_byte(8'h5A);
        @(negedge clk);
        check("full_after_last_cell", int'(full), 1);
        send_byte(8'h51);
        send_byte(8'h0D);
        send_byte(8'h08);
        @(negedge clk);
        check("no_we_when_full", int'(we), 0);
        check("full_held", int'(full), 1);
        apply_reset();
        @(negedge clk);
        check("full_cleared_by_reset", int'(full), 0);

        // Carriage return and backspace across a row boundary.
        while (m_row != 3) send_byte(8'h0D);
        while (m_col != 7) send_byte(8'($urandom_range(33, 126)));
        send_byte(8'h0D);
        send_byte(8'h08);
        send_byte(8'h61);
        send_byte(8'h08);
        send_byte(8'h08);

        // Bad stop bit, then a short low glitch.
        send_frame(8'h55, 1'b0);
        fe_exp++;
        repeat (4) tick();
        @(negedge clk);
        check("frame_error_count", fe_seen, fe_exp);
        check("no_write_on_frame_error", exp_q.size(), 0);
        RsRx = 1'b0;
        tick();
        tick();
        RsRx = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        check("busy_after_glitch", int'(busy), 0);
        check("we_after_glitch", int'(we), 0);

        // Overrun while a write is held off.
        apply_reset();
        doc_ready = 1'b0;
        send_byte(8'h58);
        send_frame(8'h59, 1'b1);
        ov_exp++;
        @(negedge clk);
        check("held_we", int'(we), 1);
        check("held_write_addr", int'(write_addr), 0);
        check("held_write_data", int'(write_data), 'h58);
        check("overrun_count", ov_seen, ov_exp);
        doc_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("we_after_accept", int'(we), 0);
        check("only_first_write", exp_q.size(), 0);
        send_byte(8'h5A);

        // Reset in the middle of data bit 4.
        apply_reset();
        b = 8'h3C;
        RsRx = 1'b0;
        repeat (c_CPB) tick();
        for (int i = 0; i < 4; i++) begin
            RsRx = b[i];
            repeat (c_CPB) tick();
        end
        RsRx = b[4];
        repeat (c_CPB / 2) tick();
        @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        RsRx = 1'b1;
        m_row = 0;
        m_col = 0;
        m_full = 1'b0;
        repeat (20) tick();
        send_byte(8'h4B);

        // Randomized traffic with a stalling write port.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else             b = 8'($urandom_range(127, 255));
            if ($urandom_range(0, 19) == 0) begin
                send_frame(b, 1'b0);
                fe_exp++;
            end else begin
                send_byte(b);
            end
        end
        rand_ready = 1'b0;
        doc_ready = 1'b1;
        enable = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("final_full", int'(full), int'(m_full));
        check("final_frame_errors", fe_seen, fe_exp);
        check("final_overruns", ov_seen, ov_exp);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
